// File: rtl/pipe_credit_buffer.sv
// Credit-tracked FIFO behind a stall-free pipeline: grants issue slots only when
// a buffer entry is guaranteed, then hands results out over ready/valid.
module pipe_credit_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  output logic                       issue_ready_out,
  input  logic                       issue_valid_in,
  input  logic                       pipe_valid_in,
  input  logic [WIDTH-1:0]           pipe_data_in,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_credits;
  logic             r_overflow;

  logic w_issue;
  logic w_pop;
  logic w_full;
  logic w_push;

  assign issue_ready_out = (r_credits != '0);
  assign valid_out       = (r_count != '0);
  assign data_out        = r_mem[r_rd_ptr];
  assign count_out       = r_count;
  assign overflow_out    = r_overflow;

  assign w_issue = issue_valid_in & issue_ready_out;
  assign w_pop   = valid_out & ready_in;
  assign w_full  = (r_count == FULL_CNT);
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign w_push  = pipe_valid_in & (~w_full | w_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_credits  <= FULL_CNT;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Decrement is safe because issue requires a nonzero credit; the
      // increment saturates so an illegal extra push cannot overrun DEPTH.
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   if (r_credits != FULL_CNT) r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase

      if (pipe_valid_in && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= pipe_data_in;
  end

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Scoreboard bench for pipe_credit_buffer fed by a 4-cycle valid pipeline model.
module tb_pipe_credit_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             issue_ready_out;
  logic             issue_valid_in;
  logic             pipe_valid_in;
  logic [WIDTH-1:0] pipe_data_in;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in;
  logic [CW-1:0]    count_out;
  logic             overflow_out;

  logic [WIDTH-1:0] issue_data;
  logic             force_pv;
  logic [WIDTH-1:0] force_d;
  logic [LAT-1:0]   r_pv;
  logic [WIDTH-1:0] r_pd [LAT];

  int total = 0;
  int bad   = 0;
  int accepts = 0;
  logic [WIDTH-1:0] q [$];

  always #5 clk_in = ~clk_in;

  pipe_credit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .issue_ready_out (issue_ready_out),
    .issue_valid_in  (issue_valid_in),
    .pipe_valid_in   (pipe_valid_in),
    .pipe_data_in    (pipe_data_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .ready_in        (ready_in),
    .count_out       (count_out),
    .overflow_out    (overflow_out)
  );

  // Fixed-latency pipeline upstream, sharing the reset.
  always @(posedge clk_in) begin
    if (rst_in) r_pv <= '0;
    else        r_pv <= {r_pv[LAT-2:0], issue_valid_in & issue_ready_out};
    r_pd[0] <= issue_data;
    for (int i = 1; i < LAT; i++) r_pd[i] <= r_pd[i-1];
  end

  assign pipe_valid_in = r_pv[LAT-1] | force_pv;
  assign pipe_data_in  = force_pv ? force_d : r_pd[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && valid_out && ready_in) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected none", data_out);
      end else begin
        check("pop_data", data_out, q.pop_front());
      end
    end
  end

  task automatic tick();
    if (!rst_in && issue_valid_in && issue_ready_out) begin
      q.push_back(issue_data);
      accepts++;
    end
    @(posedge clk_in);
    #1;
    if (rst_in) q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; issue_valid_in = 1'b0; issue_data = '0; ready_in = 1'b0;
    force_pv = 1'b0; force_d = '0;
    tick(); tick();
    rst_in = 1'b0;
    check("rst_ready", issue_ready_out, 1);
    check("rst_valid", valid_out, 0);
    check("rst_count", count_out, 0);
    check("rst_ovf", overflow_out, 0);

    // fill 8 with consumer stalled
    issue_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_data = 100 + i;
      tick();
      if (i < 7) check("fill_ready", issue_ready_out, 1);
    end
    check("fill_ready_drop", issue_ready_out, 0);
    issue_data = 999;
    tick();
    issue_valid_in = 1'b0;
    repeat (4) tick();
    check("fill_accepts", accepts, 8);
    check("full_count", count_out, 8);
    check("full_valid", valid_out, 1);

    // single pop returns one credit
    ready_in = 1'b1; tick(); ready_in = 1'b0;
    check("pop1_count", count_out, 7);
    check("pop1_ready", issue_ready_out, 1);

    // issue and pop together with one credit left
    ready_in = 1'b1; issue_valid_in = 1'b1; issue_data = 108; tick();
    ready_in = 1'b0;
    check("issue_pop_credits", issue_ready_out, 1);
    check("issue_pop_count", count_out, 6);
    issue_data = 109; tick(); issue_valid_in = 1'b0;
    repeat (4) tick();
    check("wrap_count", count_out, 8);
    check("wrap_ready", issue_ready_out, 0);

    // drain across pointer wrap
    ready_in = 1'b1; repeat (9) tick(); ready_in = 1'b0;
    check("drain_count", count_out, 0);
    check("drain_valid", valid_out, 0);
    check("drain_ready", issue_ready_out, 1);
    check("drain_sb", q.size(), 0);

    // streaming
    ready_in = 1'b1; issue_valid_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      issue_data = 200 + k;
      tick();
      check("stream_ready", issue_ready_out, 1);
      if (k >= 5) check("stream_valid", valid_out, 1);
    end
    issue_valid_in = 1'b0;
    repeat (8) tick();
    ready_in = 1'b0;
    check("stream_count", count_out, 0);
    check("stream_sb", q.size(), 0);

    // push and pop at count 3
    issue_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_data = 300 + i;
      tick();
    end
    issue_valid_in = 1'b0;
    repeat (3) tick();
    check("pp_count_pre", count_out, 3);
    ready_in = 1'b1; tick(); ready_in = 1'b0;
    check("pp_count", count_out, 3);

    // fill, then push at full with simultaneous pop
    issue_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_data = 304 + i;
      tick();
    end
    issue_valid_in = 1'b0;
    repeat (4) tick();
    check("full2_count", count_out, 8);
    check("full2_ready", issue_ready_out, 0);
    force_pv = 1'b1; force_d = 32'hAAAA_0001; ready_in = 1'b1;
    q.push_back(force_d);
    tick();
    force_pv = 1'b0; ready_in = 1'b0;
    check("fullpp_count", count_out, 8);
    check("fullpp_ovf", overflow_out, 0);

    // protocol violation
    force_pv = 1'b1; force_d = 32'hBBBB_0002; tick(); force_pv = 1'b0;
    check("ovf_set", overflow_out, 1);
    check("ovf_count", count_out, 8);
    repeat (3) tick();
    check("ovf_sticky", overflow_out, 1);
    ready_in = 1'b1; repeat (9) tick(); ready_in = 1'b0;
    check("ovf_drain_count", count_out, 0);
    check("ovf_drain_sb", q.size(), 0);
    check("ovf_hold", overflow_out, 1);

    // mid-stream reset: 5 stored, 3 in flight
    issue_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_data = 400 + i;
      tick();
    end
    issue_valid_in = 1'b0;
    tick();
    check("mr_count_pre", count_out, 5);
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    check("mr_count", count_out, 0);
    check("mr_valid", valid_out, 0);
    check("mr_ovf", overflow_out, 0);
    check("mr_ready", issue_ready_out, 1);
    repeat (6) tick();
    check("mr_no_late_count", count_out, 0);
    check("mr_no_late_valid", valid_out, 0);

    accepts = 0;
    issue_valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue_data = 500 + i;
      tick();
    end
    issue_valid_in = 1'b0;
    check("mr_accepts", accepts, 8);
    repeat (4) tick();
    check("mr_full_count", count_out, 8);
    ready_in = 1'b1; repeat (9) tick(); ready_in = 1'b0;
    check("mr_drain_count", count_out, 0);
    check("mr_drain_sb", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
